pifo_reg_ctrl: RTL and testbench

Scheduler/controller in front of one `pifo_reg` instance. It round-robin arbitrates up to NUM_ENQ enqueue requesters and one dequeue requester onto the PIFO's single insert/remove port. It sequences each operation through the PIFO's min/max recompute window and returns the dequeued rank/meta to the consumer. When the PIFO is full, it drops enqueues whose rank is not below the current maximum, and does not forward them.

---
 rtl/pifo_reg_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pifo_reg_ctrl.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_reg_ctrl.sv
// Round-robin scheduler in front of a single pifo_reg: arbitrates NUM_ENQ enqueuers and one dequeuer
// onto the PIFO port, drops enqueues that cannot enter a full PIFO. Optional drop statistics: PIFO_CTRL_STATS_EN.
module pifo_reg_ctrl #(
    parameter int NUM_ENQ      = 4,
    parameter int RANK_WIDTH   = 8,
    parameter int META_WIDTH   = 8,
    parameter int L2_REG_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ENQ-1:0]            enq_req,
    input  logic [NUM_ENQ*RANK_WIDTH-1:0] enq_rank,
    input  logic [NUM_ENQ*META_WIDTH-1:0] enq_meta,
    output logic [NUM_ENQ-1:0]            enq_ack,
    input  logic                          deq_req,
    output logic                          deq_ack,
    output logic [RANK_WIDTH-1:0]         deq_rank,
    output logic [META_WIDTH-1:0]         deq_meta,
    output logic                          pifo_insert,
    output logic                          pifo_remove,
    output logic [RANK_WIDTH-1:0]         pifo_rank_in,
    output logic [META_WIDTH-1:0]         pifo_meta_in,
    input  logic [RANK_WIDTH-1:0]         pifo_rank_out,
    input  logic [META_WIDTH-1:0]         pifo_meta_out,
    input  logic                          pifo_valid_out,
    input  logic [RANK_WIDTH-1:0]         pifo_max_rank_out,
    input  logic                          pifo_full,
    input  logic                          pifo_empty,
    output logic                          busy,
    output logic [31:0]                   drop_cnt
);

    localparam int PTR_W = (NUM_ENQ > 1) ? $clog2(NUM_ENQ) : 1;

    if (NUM_ENQ < 1 || NUM_ENQ > 8 || L2_REG_WIDTH < 1) begin : g_bad_params
        $error("pifo_reg_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    prio_deq_q, prio_deq_d;
    logic [NUM_ENQ-1:0]      enq_ack_q, enq_ack_d;
    logic                    deq_ack_q, deq_ack_d;
    logic [RANK_WIDTH-1:0]   deq_rank_q, deq_rank_d;
    logic [META_WIDTH-1:0]   deq_meta_q, deq_meta_d;
    logic                    insert_q, insert_d;
    logic                    remove_q, remove_d;
    logic [RANK_WIDTH-1:0]   rank_in_q, rank_in_d;
    logic [META_WIDTH-1:0]   meta_in_q, meta_in_d;

    logic [NUM_ENQ-1:0]      req_eff;
    logic                    win_found;
    logic [PTR_W-1:0]        win_idx;
    logic [PTR_W:0]          cand;
    logic [PTR_W:0]          rr_next;
    logic [RANK_WIDTH-1:0]   win_rank;
    logic [META_WIDTH-1:0]   win_meta;
    logic                    in_idle;
    logic                    deq_elig;
    logic                    enq_elig;
    logic                    serve_deq;
    logic                    serve_enq;
    logic                    drop;

    // Handshake: a requester holds req/rank/meta until its one-cycle ack; the ack itself marks acceptance
    // (or drop). A requester whose ack is high this cycle is masked so a dropped entry is not served twice.
    assign req_eff  = enq_req & ~enq_ack_q;
    assign in_idle  = (state_q == S_IDLE);
    assign deq_elig = in_idle & deq_req & pifo_valid_out & ~pifo_empty;
    assign enq_elig = in_idle & win_found;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_ENQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_ENQ)) begin
                cand = cand - (PTR_W+1)'(NUM_ENQ);
            end
            if (!win_found && req_eff[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_rank = '0;
        win_meta = '0;
        for (int i = 0; i < NUM_ENQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_rank = enq_rank[i*RANK_WIDTH +: RANK_WIDTH];
                win_meta = enq_meta[i*META_WIDTH +: META_WIDTH];
            end
        end
        rr_next = {1'b0, win_idx} + (PTR_W+1)'(1);
        if (rr_next == (PTR_W+1)'(NUM_ENQ)) begin
            rr_next = '0;
        end
    end

    // prio_deq only matters when both sides compete; a lone candidate always wins.
    assign serve_deq = deq_elig & (~enq_elig | prio_deq_q);
    assign serve_enq = enq_elig & ~serve_deq;
    assign drop      = serve_enq & pifo_full & (win_rank >= pifo_max_rank_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (serve_deq || (serve_enq && !drop)) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enq_ack_d  = '0;
        deq_ack_d  = 1'b0;
        insert_d   = 1'b0;
        remove_d   = 1'b0;
        rank_in_d  = rank_in_q;
        meta_in_d  = meta_in_q;
        deq_rank_d = deq_rank_q;
        deq_meta_d = deq_meta_q;
        rr_ptr_d   = rr_ptr_q;
        prio_deq_d = prio_deq_q;
        if (serve_deq) begin
            deq_ack_d  = 1'b1;
            remove_d   = 1'b1;
            deq_rank_d = pifo_rank_out;
            deq_meta_d = pifo_meta_out;
            prio_deq_d = ~prio_deq_q;
        end else if (serve_enq) begin
            enq_ack_d[win_idx] = 1'b1;
            rr_ptr_d           = rr_next[PTR_W-1:0];
            prio_deq_d         = ~prio_deq_q;
            if (!drop) begin
                insert_d  = 1'b1;
                rank_in_d = win_rank;
                meta_in_d = win_meta;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            prio_deq_q <= 1'b1;
            enq_ack_q  <= '0;
            deq_ack_q  <= 1'b0;
            insert_q   <= 1'b0;
            remove_q   <= 1'b0;
            rank_in_q  <= '0;
            meta_in_q  <= '0;
            deq_rank_q <= '0;
            deq_meta_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            prio_deq_q <= prio_deq_d;
            enq_ack_q  <= enq_ack_d;
            deq_ack_q  <= deq_ack_d;
            insert_q   <= insert_d;
            remove_q   <= remove_d;
            rank_in_q  <= rank_in_d;
            meta_in_q  <= meta_in_d;
            deq_rank_q <= deq_rank_d;
            deq_meta_q <= deq_meta_d;
        end
    end

`ifdef PIFO_CTRL_STATS_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 32'hFFFF_FFFF) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 32'd0;
`endif

    assign enq_ack      = enq_ack_q;
    assign deq_ack      = deq_ack_q;
    assign deq_rank     = deq_rank_q;
    assign deq_meta     = deq_meta_q;
    assign pifo_insert  = insert_q;
    assign pifo_remove  = remove_q;
    assign pifo_rank_in = rank_in_q;
    assign pifo_meta_in = meta_in_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_pifo_reg_ctrl.sv
// Bench for pifo_reg_ctrl with a behavioural 4-entry PIFO model standing in for pifo_reg.
module tb_pifo_reg_ctrl;

    localparam int NUM_ENQ = 4;
    localparam int RW      = 8;
    localparam int MW      = 8;
    localparam int DEPTH   = 4;
`ifdef PIFO_CTRL_STATS_EN
    localparam int STATS_EN = 1;
`else
    localparam int STATS_EN = 0;
`endif

    logic                  clk;
    logic                  rst;
    logic [NUM_ENQ-1:0]    enq_req;
    logic [NUM_ENQ*RW-1:0] enq_rank;
    logic [NUM_ENQ*MW-1:0] enq_meta;
    logic [NUM_ENQ-1:0]    enq_ack;
    logic                  deq_req;
    logic                  deq_ack;
    logic [RW-1:0]         deq_rank;
    logic [MW-1:0]         deq_meta;
    logic                  pifo_insert;
    logic                  pifo_remove;
    logic [RW-1:0]         pifo_rank_in;
    logic [MW-1:0]         pifo_meta_in;
    logic [RW-1:0]         pifo_rank_out;
    logic [MW-1:0]         pifo_meta_out;
    logic                  pifo_valid_out;
    logic [RW-1:0]         pifo_max_rank_out;
    logic                  pifo_full;
    logic                  pifo_empty;
    logic                  busy;
    logic [31:0]           drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    pifo_reg_ctrl #(
        .NUM_ENQ(NUM_ENQ), .RANK_WIDTH(RW), .META_WIDTH(MW), .L2_REG_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_req(enq_req), .enq_rank(enq_rank), .enq_meta(enq_meta), .enq_ack(enq_ack),
        .deq_req(deq_req), .deq_ack(deq_ack), .deq_rank(deq_rank), .deq_meta(deq_meta),
        .pifo_insert(pifo_insert), .pifo_remove(pifo_remove),
        .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
        .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out),
        .pifo_valid_out(pifo_valid_out), .pifo_max_rank_out(pifo_max_rank_out),
        .pifo_full(pifo_full), .pifo_empty(pifo_empty),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- PIFO model ----------------
    logic [RW-1:0] m_rank [DEPTH];
    logic [MW-1:0] m_meta [DEPTH];
    int            m_cnt;
    logic          m_recomp;
    logic [RW-1:0] n_rank [DEPTH];
    logic [MW-1:0] n_meta [DEPTH];
    int            n_cnt;
    int            n_pos;
    bit            n_done;
    logic [RW-1:0] m_max;

    always_comb begin
        n_rank = m_rank;
        n_meta = m_meta;
        n_cnt  = m_cnt;
        n_pos  = 0;
        n_done = 1'b0;
        if (pifo_insert) begin
            if (n_cnt == DEPTH) n_cnt = n_cnt - 1;
            n_pos = n_cnt;
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if (i <= n_cnt && !n_done) begin
                    if (n_rank[i-1] > pifo_rank_in) begin
                        n_rank[i] = n_rank[i-1];
                        n_meta[i] = n_meta[i-1];
                        n_pos     = i - 1;
                    end else begin
                        n_done = 1'b1;
                    end
                end
            end
            n_rank[n_pos] = pifo_rank_in;
            n_meta[n_pos] = pifo_meta_in;
            n_cnt = n_cnt + 1;
        end else if (pifo_remove && n_cnt > 0) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                n_rank[i] = n_rank[i+1];
                n_meta[i] = n_meta[i+1];
            end
            n_cnt = n_cnt - 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt    <= 0;
            m_recomp <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                m_rank[i] <= '0;
                m_meta[i] <= '0;
            end
        end else begin
            m_rank   <= n_rank;
            m_meta   <= n_meta;
            m_cnt    <= n_cnt;
            m_recomp <= pifo_insert | pifo_remove;
        end
    end

    always_comb begin
        m_max = '0;
        for (int i = 0; i < DEPTH; i++) if (i == m_cnt - 1) m_max = m_rank[i];
    end

    assign pifo_rank_out     = (m_cnt > 0) ? m_rank[0] : '0;
    assign pifo_meta_out     = (m_cnt > 0) ? m_meta[0] : '0;
    assign pifo_max_rank_out = m_max;
    assign pifo_full         = (m_cnt == DEPTH);
    assign pifo_empty        = (m_cnt == 0);
    assign pifo_valid_out    = (m_cnt > 0) && !m_recomp;

    // insert and remove must never coincide
    always @(negedge clk) begin
        if (!rst && (pifo_insert || pifo_remove)) begin
            checks++;
            if (pifo_insert && pifo_remove) begin
                errors++;
                $display("FAIL cmd_exclusive: insert=%b remove=%b required not both", pifo_insert, pifo_remove);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst = 1'b1;
        enq_req = '0;
        deq_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_enq(input int id, input logic [RW-1:0] r, input logic [MW-1:0] m);
        enq_rank[id*RW +: RW] = r;
        enq_meta[id*MW +: MW] = m;
    endtask

    // Waits at falling edges for the next ack; ev = {1,id} for enqueue, {2,rank} for dequeue, FFFF on timeout.
    task automatic wait_event(input int budget, output logic [15:0] ev, output int cycles);
        ev = 16'hFFFF;
        cycles = 0;
        while (cycles < budget && ev == 16'hFFFF) begin
            @(negedge clk);
            cycles++;
            if (deq_ack) begin
                ev = {8'h02, deq_rank};
            end else if (enq_ack != '0) begin
                for (int i = 0; i < NUM_ENQ; i++) if (enq_ack[i]) ev = {8'h01, 8'(i)};
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 6) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic drive_enq(input int id, input logic [RW-1:0] r, input logic [MW-1:0] m);
        logic [15:0] ev;
        logic [15:0] exp;
        int cyc;
        set_enq(id, r, m);
        enq_req[id] = 1'b1;
        exp_q.push_back({8'h01, 8'(id)});
        wait_event(20, ev, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (ev !== exp) begin
            errors++;
            $display("FAIL enq_ack_req%0d: got %h required %h", id, ev, exp);
        end
        enq_req[id] = 1'b0;
        wait_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        enq_req = 4'hF;
        deq_req = 1'b1;
        for (int i = 0; i < NUM_ENQ; i++) set_enq(i, 8'(i + 1), 8'(i + 8'h40));
        repeat (3) @(negedge clk);
        checks++;
        if ({enq_ack, deq_ack, pifo_insert, pifo_remove, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: ack/cmd/busy=%b required 0", {enq_ack, deq_ack, pifo_insert, pifo_remove, busy});
        end
        checks++;
        if ({deq_rank, deq_meta, pifo_rank_in, pifo_meta_in} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: %h required 0", {deq_rank, deq_meta, pifo_rank_in, pifo_meta_in});
        end
        checks++;
        if (drop_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: %0d required 0", drop_cnt);
        end
        enq_req = '0;
        deq_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_enq();
        reset_dut();
        set_enq(0, 8'd5, 8'hA1);
        enq_req[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({enq_ack, pifo_insert, pifo_remove, busy} !== 7'b0001_101) begin
            errors++;
            $display("FAIL single_issue: ack=%b ins=%b rem=%b busy=%b required 0001 1 0 1",
                     enq_ack, pifo_insert, pifo_remove, busy);
        end
        checks++;
        if ({pifo_rank_in, pifo_meta_in} !== {8'd5, 8'hA1}) begin
            errors++;
            $display("FAIL single_data: %h required 05a1", {pifo_rank_in, pifo_meta_in});
        end
        enq_req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({enq_ack, pifo_insert, busy} !== 6'b0000_01) begin
            errors++;
            $display("FAIL single_wait: ack=%b ins=%b busy=%b required 0000 0 1", enq_ack, pifo_insert, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b required 0", busy);
        end
        deq_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({deq_ack, pifo_remove, deq_rank, deq_meta} !== {2'b11, 8'd5, 8'hA1}) begin
            errors++;
            $display("FAIL single_deq: ack=%b rem=%b data=%h required 1 1 05a1",
                     deq_ack, pifo_remove, {deq_rank, deq_meta});
        end
        deq_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_round_robin();
        logic [15:0] ev;
        logic [15:0] exp;
        int cyc;
        reset_dut();
        for (int i = 0; i < NUM_ENQ; i++) set_enq(i, 8'(10 * i + 1), 8'(i));
        enq_req = 4'hF;
        for (int i = 0; i < NUM_ENQ; i++) exp_q.push_back({8'h01, 8'(i)});
        for (int n = 0; n < NUM_ENQ; n++) begin
            wait_event(12, ev, cyc);
            exp = exp_q.pop_front();
            checks++;
            if (ev !== exp || cyc != ((n == 0) ? 1 : 3)) begin
                errors++;
                $display("FAIL rr_order_%0d: got %h after %0d cycles required %h after %0d",
                         n, ev, cyc, exp, (n == 0) ? 1 : 3);
            end
            if (ev[15:8] == 8'h01) enq_req[ev[1:0]] = 1'b0;
        end
        wait_idle();

        reset_dut();
        enq_req = 4'hF;
        exp_q.push_back({8'h01, 8'd0});
        exp_q.push_back({8'h01, 8'd1});
        for (int n = 0; n < 2; n++) begin
            wait_event(12, ev, cyc);
            exp = exp_q.pop_front();
            checks++;
            if (ev !== exp) begin
                errors++;
                $display("FAIL rr_pre_reset_%0d: got %h required %h", n, ev, exp);
            end
            if (ev[15:8] == 8'h01) enq_req[ev[1:0]] = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, enq_ack, pifo_insert} !== 6'b0) begin
            errors++;
            $display("FAIL rr_async_abort: busy/ack/ins=%b required 0", {busy, enq_ack, pifo_insert});
        end
        enq_req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        enq_req = 4'hF;
        exp_q.push_back({8'h01, 8'd0});
        wait_event(12, ev, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (ev !== exp) begin
            errors++;
            $display("FAIL rr_after_reset: got %h required %h", ev, exp);
        end
        enq_req = '0;
        wait_idle();
    endtask

    task automatic test_deq_order();
        logic [15:0] ev;
        logic [15:0] exp;
        int cyc;
        reset_dut();
        drive_enq(0, 8'd7, 8'h17);
        drive_enq(0, 8'd3, 8'h13);
        drive_enq(0, 8'd9, 8'h19);
        exp_q.push_back({8'h02, 8'd3});
        exp_q.push_back({8'h02, 8'd7});
        exp_q.push_back({8'h02, 8'd9});
        deq_req = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_event(12, ev, cyc);
            exp = exp_q.pop_front();
            checks++;
            if (ev !== exp || deq_meta !== exp[7:0] + 8'h10) begin
                errors++;
                $display("FAIL deq_order_%0d: got %h meta %h required %h meta %h",
                         n, ev, deq_meta, exp, exp[7:0] + 8'h10);
            end
        end
        wait_event(10, ev, cyc);
        checks++;
        if (ev !== 16'hFFFF) begin
            errors++;
            $display("FAIL deq_empty_noack: got %h required no ack", ev);
        end
        checks++;
        if ({deq_rank, deq_meta} !== {8'd9, 8'h19}) begin
            errors++;
            $display("FAIL deq_hold: %h required 0919", {deq_rank, deq_meta});
        end
        deq_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_drop();
        logic [15:0] ev;
        logic [15:0] exp;
        int cyc;
        reset_dut();
        drive_enq(0, 8'd1, 8'h01);
        drive_enq(0, 8'd4, 8'h04);
        drive_enq(0, 8'd9, 8'h09);
        drive_enq(0, 8'd6, 8'h06);
        set_enq(2, 8'd9, 8'h99);
        enq_req[2] = 1'b1;
        @(negedge clk);
        checks++;
        if ({enq_ack, pifo_insert, busy} !== 6'b0100_00) begin
            errors++;
            $display("FAIL drop_equal_max: ack=%b ins=%b busy=%b required 0100 0 0", enq_ack, pifo_insert, busy);
        end
        checks++;
        if (drop_cnt !== 32'(STATS_EN)) begin
            errors++;
            $display("FAIL drop_cnt_1: %0d required %0d", drop_cnt, STATS_EN);
        end
        enq_req[2] = 1'b0;
        @(negedge clk);
        checks++;
        if ({enq_ack, pifo_insert} !== 5'b0) begin
            errors++;
            $display("FAIL drop_no_reack: ack=%b ins=%b required 0", enq_ack, pifo_insert);
        end
        set_enq(2, 8'd2, 8'h22);
        enq_req[2] = 1'b1;
        @(negedge clk);
        checks++;
        if ({enq_ack, pifo_insert, pifo_rank_in} !== {4'b0100, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL full_accept: ack=%b ins=%b rank=%0d required 0100 1 2", enq_ack, pifo_insert, pifo_rank_in);
        end
        enq_req[2] = 1'b0;
        wait_idle();

        // back-to-back drops, one per cycle
        set_enq(0, 8'd200, 8'hC8);
        set_enq(1, 8'd255, 8'hFF);
        enq_req[1:0] = 2'b11;
        exp_q.push_back({8'h01, 8'd0});
        exp_q.push_back({8'h01, 8'd1});
        for (int n = 0; n < 2; n++) begin
            wait_event(5, ev, cyc);
            exp = exp_q.pop_front();
            checks++;
            if (ev !== exp || cyc != 1 || pifo_insert !== 1'b0) begin
                errors++;
                $display("FAIL drop_b2b_%0d: got %h after %0d ins=%b required %h after 1 ins=0",
                         n, ev, cyc, pifo_insert, exp);
            end
            if (ev[15:8] == 8'h01) enq_req[ev[1:0]] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (drop_cnt !== 32'(3 * STATS_EN)) begin
            errors++;
            $display("FAIL drop_cnt_3: %0d required %0d", drop_cnt, 3 * STATS_EN);
        end

        exp_q.push_back({8'h02, 8'd1});
        exp_q.push_back({8'h02, 8'd2});
        deq_req = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_event(12, ev, cyc);
            exp = exp_q.pop_front();
            checks++;
            if (ev !== exp) begin
                errors++;
                $display("FAIL drop_deq_%0d: got %h required %h", n, ev, exp);
            end
        end
        deq_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_contention();
        logic [15:0] ev;
        logic [15:0] exp;
        int cyc;
        reset_dut();
        drive_enq(0, 8'd10, 8'h0A);
        drive_enq(0, 8'd20, 8'h14);
        set_enq(1, 8'd50, 8'h55);
        enq_req[1] = 1'b1;
        deq_req = 1'b1;
        exp_q.push_back({8'h02, 8'd10});
        exp_q.push_back({8'h01, 8'd1});
        exp_q.push_back({8'h02, 8'd20});
        exp_q.push_back({8'h01, 8'd1});
        for (int n = 0; n < 4; n++) begin
            wait_event(12, ev, cyc);
            exp = exp_q.pop_front();
            checks++;
            if (ev !== exp || cyc != ((n == 0) ? 1 : 3)) begin
                errors++;
                $display("FAIL contention_%0d: got %h after %0d cycles required %h after %0d",
                         n, ev, cyc, exp, (n == 0) ? 1 : 3);
            end
        end
        enq_req = '0;
        deq_req = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        enq_req = '0;
        enq_rank = '0;
        enq_meta = '0;
        deq_req = 1'b0;
        test_reset();
        test_single_enq();
        test_round_robin();
        test_deq_order();
        test_full_drop();
        test_contention();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
